// File: rtl/fmdll_lock_ctrl.sv
`default_nettype none
//============================================================================
// Module   : fmdll_lock_ctrl
// Brief    : FMDLL lock controller - M/N frame counters, 10-step SAR search on
//            COMP, optional +/-1 tracking with lock detect (LOCK_CTRL_TRACK_EN).
// Revision : 1.0
//============================================================================
module fmdll_lock_ctrl #(
  parameter int QW       = 10,
  parameter int LOCK_CNT = 4
) (
  input  logic          clk_ext,
  input  logic          Reset_CTRL,
  input  logic          Enable,
  input  logic [1:0]    M,
  input  logic [3:0]    N,
  input  logic          COMP,
  output logic [1:0]    M_counter,
  output logic [3:0]    N_counter,
  output logic [QW-1:0] Q,
  output logic [QW-1:0] Q_next,
  output logic          Reset_PD,
  output logic          Locked,
  output logic          Cal_done
);

  localparam int            c_IW  = $clog2(QW);
  localparam logic [QW-1:0] c_ONE = {{(QW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PDRST = 3'd1,
    S_SAR   = 3'd2,
    S_TRACK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state,       w_state_nxt;
  logic            r_pd_cnt,      w_pd_cnt_nxt;
  logic [1:0]      r_m_cnt,       w_m_cnt_nxt;
  logic [3:0]      r_n_cnt,       w_n_cnt_nxt;
  logic [1:0]      r_m_eff,       w_m_eff_nxt;
  logic [3:0]      r_n_eff,       w_n_eff_nxt;
  logic [QW-1:0]   r_q,           w_q_nxt;
  logic [QW-1:0]   r_q_next,      w_q_next_nxt;
  logic [c_IW-1:0] r_bit_idx,     w_bit_idx_nxt;
  logic            r_first_frame, w_first_frame_nxt;
  logic            r_reset_pd,    w_reset_pd_nxt;
  logic            r_locked,      w_locked_nxt;
  logic            r_cal_done,    w_cal_done_nxt;
`ifdef LOCK_CTRL_TRACK_EN
  localparam logic [3:0] c_LOCK_CNT = 4'(LOCK_CNT);
  logic [3:0]      r_rev_cnt,     w_rev_cnt_nxt;
  logic            r_last_up,     w_last_up_nxt;
  logic            r_dir_valid,   w_dir_valid_nxt;
`endif

  logic [1:0]    w_m_eff_in;
  logic [3:0]    w_n_eff_in;
  logic          w_wrap;
  logic          w_decide;
  logic [QW-1:0] w_q_sel;

  function automatic logic [QW-1:0] f_inc(input logic [QW-1:0] v);
    return (v == {QW{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [QW-1:0] f_dec(input logic [QW-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  assign w_m_eff_in = (M == 2'd0) ? 2'd1 : M;
  assign w_n_eff_in = (N < 4'd2)  ? 4'd2 : N;
  // Last cycle of a frame: the next edge returns the counters to (1,1).
  assign w_wrap   = (r_n_cnt == r_n_eff) && (r_m_cnt == r_m_eff);
  assign w_decide = w_wrap && !r_first_frame;
  assign w_q_sel  = COMP ? r_q_next : r_q;

  always_comb begin
    w_state_nxt       = r_state;
    w_pd_cnt_nxt      = r_pd_cnt;
    w_m_cnt_nxt       = r_m_cnt;
    w_n_cnt_nxt       = r_n_cnt;
    w_m_eff_nxt       = r_m_eff;
    w_n_eff_nxt       = r_n_eff;
    w_q_nxt           = r_q;
    w_q_next_nxt      = r_q_next;
    w_bit_idx_nxt     = r_bit_idx;
    w_first_frame_nxt = r_first_frame;
    w_reset_pd_nxt    = r_reset_pd;
    w_locked_nxt      = r_locked;
    w_cal_done_nxt    = r_cal_done;
`ifdef LOCK_CTRL_TRACK_EN
    w_rev_cnt_nxt     = r_rev_cnt;
    w_last_up_nxt     = r_last_up;
    w_dir_valid_nxt   = r_dir_valid;
`endif

    if (!Enable) begin
      w_state_nxt    = S_IDLE;
      w_reset_pd_nxt = 1'b1;
      w_m_cnt_nxt    = 2'd1;
      w_n_cnt_nxt    = 4'd1;
      w_m_eff_nxt    = w_m_eff_in;
      w_n_eff_nxt    = w_n_eff_in;
      w_locked_nxt   = 1'b0;
      w_cal_done_nxt = 1'b0;
`ifdef LOCK_CTRL_TRACK_EN
      w_rev_cnt_nxt   = 4'd0;
      w_dir_valid_nxt = 1'b0;
`endif
    end else if (r_state == S_IDLE || r_state == S_PDRST) begin
      w_reset_pd_nxt = 1'b1;
      w_m_cnt_nxt    = 2'd1;
      w_n_cnt_nxt    = 4'd1;
      w_m_eff_nxt    = w_m_eff_in;
      w_n_eff_nxt    = w_n_eff_in;
      if (r_state == S_IDLE) begin
        w_state_nxt  = S_PDRST;
        w_pd_cnt_nxt = 1'b0;
      end else begin
        w_q_nxt = '0;
        if (r_pd_cnt) begin
          w_state_nxt       = S_SAR;
          w_reset_pd_nxt    = 1'b0;
          w_bit_idx_nxt     = c_IW'(QW-1);
          w_q_next_nxt      = c_ONE << (QW-1);
          w_first_frame_nxt = 1'b1;
        end else begin
          w_pd_cnt_nxt = 1'b1;
        end
      end
    end else begin
      // Frame counters; new M/N only take effect on the wrap to (1,1).
      if (r_n_cnt == r_n_eff) begin
        w_n_cnt_nxt = 4'd1;
        if (r_m_cnt == r_m_eff) begin
          w_m_cnt_nxt = 2'd1;
          w_m_eff_nxt = w_m_eff_in;
          w_n_eff_nxt = w_n_eff_in;
        end else begin
          w_m_cnt_nxt = r_m_cnt + 2'd1;
        end
      end else begin
        w_n_cnt_nxt = r_n_cnt + 4'd1;
      end
      if (r_m_cnt == 2'd1 && r_n_cnt == 4'd1)
        w_first_frame_nxt = 1'b0;

      case (r_state)
        S_SAR: begin
          if (w_decide) begin
            w_q_nxt = w_q_sel;
            if (r_bit_idx == '0) begin
              w_cal_done_nxt = 1'b1;
`ifdef LOCK_CTRL_TRACK_EN
              w_state_nxt  = S_TRACK;
              w_q_next_nxt = f_inc(w_q_sel);
`else
              w_state_nxt  = S_DONE;
              w_q_next_nxt = w_q_sel;
              w_locked_nxt = 1'b1;
`endif
            end else begin
              w_bit_idx_nxt = r_bit_idx - 1'b1;
              w_q_next_nxt  = w_q_sel | (c_ONE << (r_bit_idx - 1'b1));
            end
          end
        end
`ifdef LOCK_CTRL_TRACK_EN
        S_TRACK: begin
          if (w_decide) begin
            w_q_nxt      = COMP ? f_inc(r_q) : f_dec(r_q);
            w_q_next_nxt = f_inc(w_q_nxt);
            if (r_dir_valid && (COMP != r_last_up))
              w_rev_cnt_nxt = (r_rev_cnt == 4'd15) ? r_rev_cnt : r_rev_cnt + 4'd1;
            else if (r_dir_valid)
              w_rev_cnt_nxt = 4'd0;
            w_last_up_nxt   = COMP;
            w_dir_valid_nxt = 1'b1;
            if (w_rev_cnt_nxt >= c_LOCK_CNT)
              w_locked_nxt = 1'b1;
          end
        end
`endif
        S_DONE:  ;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_ext) begin
    if (Reset_CTRL) begin
      r_state       <= S_IDLE;
      r_pd_cnt      <= 1'b0;
      r_m_cnt       <= 2'd1;
      r_n_cnt       <= 4'd1;
      r_m_eff       <= 2'd1;
      r_n_eff       <= 4'd2;
      r_q           <= '0;
      r_q_next      <= '0;
      r_bit_idx     <= '0;
      r_first_frame <= 1'b0;
      r_reset_pd    <= 1'b1;
      r_locked      <= 1'b0;
      r_cal_done    <= 1'b0;
`ifdef LOCK_CTRL_TRACK_EN
      r_rev_cnt     <= 4'd0;
      r_last_up     <= 1'b0;
      r_dir_valid   <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_pd_cnt      <= w_pd_cnt_nxt;
      r_m_cnt       <= w_m_cnt_nxt;
      r_n_cnt       <= w_n_cnt_nxt;
      r_m_eff       <= w_m_eff_nxt;
      r_n_eff       <= w_n_eff_nxt;
      r_q           <= w_q_nxt;
      r_q_next      <= w_q_next_nxt;
      r_bit_idx     <= w_bit_idx_nxt;
      r_first_frame <= w_first_frame_nxt;
      r_reset_pd    <= w_reset_pd_nxt;
      r_locked      <= w_locked_nxt;
      r_cal_done    <= w_cal_done_nxt;
`ifdef LOCK_CTRL_TRACK_EN
      r_rev_cnt     <= w_rev_cnt_nxt;
      r_last_up     <= w_last_up_nxt;
      r_dir_valid   <= w_dir_valid_nxt;
`endif
    end
  end

  assign M_counter = r_m_cnt;
  assign N_counter = r_n_cnt;
  assign Q         = r_q;
  assign Q_next    = r_q_next;
  assign Reset_PD  = r_reset_pd;
  assign Locked    = r_locked;
  assign Cal_done  = r_cal_done;

endmodule
`default_nettype wire

// File: tb/tb_fmdll_lock_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_fmdll_lock_ctrl
// Brief    : Directed self-checking bench for fmdll_lock_ctrl.
// Revision : 1.0
//============================================================================
module tb_fmdll_lock_ctrl;

  localparam int QW = 10;

  logic          clk_ext = 1'b0;
  logic          Reset_CTRL = 1'b1;
  logic          Enable = 1'b0;
  logic [1:0]    M = 2'd2;
  logic [3:0]    N = 4'd4;
  logic          COMP;
  logic          comp_fix = 1'b0;
  logic          comp_m = 1'b0;
  logic          comp_model = 1'b0;
  logic [1:0]    M_counter;
  logic [3:0]    N_counter;
  logic [QW-1:0] Q;
  logic [QW-1:0] Q_next;
  logic          Reset_PD;
  logic          Locked;
  logic          Cal_done;

  int errors = 0;
  int checks = 0;

  fmdll_lock_ctrl #(.QW(QW), .LOCK_CNT(4)) dut (
    .clk_ext    (clk_ext),
    .Reset_CTRL (Reset_CTRL),
    .Enable     (Enable),
    .M          (M),
    .N          (N),
    .COMP       (COMP),
    .M_counter  (M_counter),
    .N_counter  (N_counter),
    .Q          (Q),
    .Q_next     (Q_next),
    .Reset_PD   (Reset_PD),
    .Locked     (Locked),
    .Cal_done   (Cal_done)
  );

  always #5 clk_ext = ~clk_ext;

  // Phase detector stand-in: judges the trial code during SAR, the committed code afterwards.
  always @(negedge clk_ext)
    comp_m = Cal_done ? (Q <= 10'd600) : (Q_next <= 10'd600);

  assign COMP = comp_model ? comp_m : comp_fix;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_ext);
    #1;
  endtask

  task automatic do_reset();
    Reset_CTRL = 1'b1;
    Enable     = 1'b0;
    tick(2);
    Reset_CTRL = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (Q !== 10'd0)        begin errors++; $display("FAIL reset_Q: got %0d want 0", Q); end
    if (Q_next !== 10'd0)   begin errors++; $display("FAIL reset_Q_next: got %0d want 0", Q_next); end
    if (M_counter !== 2'd1) begin errors++; $display("FAIL reset_M_counter: got %0d want 1", M_counter); end
    if (N_counter !== 4'd1) begin errors++; $display("FAIL reset_N_counter: got %0d want 1", N_counter); end
    if (Reset_PD !== 1'b1)  begin errors++; $display("FAIL reset_Reset_PD: got %0b want 1", Reset_PD); end
    if (Locked !== 1'b0)    begin errors++; $display("FAIL reset_Locked: got %0b want 0", Locked); end
    if (Cal_done !== 1'b0)  begin errors++; $display("FAIL reset_Cal_done: got %0b want 0", Cal_done); end
  endtask

  task automatic test_comp_high();
    logic exp_lock;
    M = 2'd2; N = 4'd4; comp_model = 1'b0; comp_fix = 1'b1;
    do_reset();
    Enable = 1'b1;
    tick(2);
    checks++;
    if (Reset_PD !== 1'b1) begin errors++; $display("FAIL hi_pd_edge2: got %0b want 1", Reset_PD); end
    tick(1);
    checks += 2;
    if (Reset_PD !== 1'b0)   begin errors++; $display("FAIL hi_pd_edge3: got %0b want 0", Reset_PD); end
    if (Q_next !== 10'd512)  begin errors++; $display("FAIL hi_first_trial: got %0d want 512", Q_next); end
    tick(79);
    checks++;
    if (Cal_done !== 1'b0) begin errors++; $display("FAIL hi_cal_early: got %0b want 0", Cal_done); end
    tick(1);
`ifdef LOCK_CTRL_TRACK_EN
    exp_lock = 1'b0;
`else
    exp_lock = 1'b1;
`endif
    checks += 4;
    if (Cal_done !== 1'b1)   begin errors++; $display("FAIL hi_cal_done: got %0b want 1", Cal_done); end
    if (Q !== 10'd1023)      begin errors++; $display("FAIL hi_Q: got %0d want 1023", Q); end
    if (Q_next !== 10'd1023) begin errors++; $display("FAIL hi_Q_next: got %0d want 1023", Q_next); end
    if (Locked !== exp_lock) begin errors++; $display("FAIL hi_Locked: got %0b want %0b", Locked, exp_lock); end
  endtask

  task automatic test_comp_low();
    logic [QW-1:0] exp_qn;
    M = 2'd2; N = 4'd4; comp_model = 1'b0; comp_fix = 1'b0;
    do_reset();
    Enable = 1'b1;
    tick(3 + 80);
`ifdef LOCK_CTRL_TRACK_EN
    exp_qn = 10'd1;
`else
    exp_qn = 10'd0;
`endif
    checks += 3;
    if (Q !== 10'd0)        begin errors++; $display("FAIL lo_Q: got %0d want 0", Q); end
    if (Q_next !== exp_qn)  begin errors++; $display("FAIL lo_Q_next: got %0d want %0d", Q_next, exp_qn); end
    if (Cal_done !== 1'b1)  begin errors++; $display("FAIL lo_cal_done: got %0b want 1", Cal_done); end
  endtask

  task automatic test_sar_search();
    logic [QW-1:0] trial [10];
    logic [QW-1:0] exp_qn;
    trial = '{10'd512, 10'd768, 10'd640, 10'd576, 10'd608,
              10'd592, 10'd600, 10'd604, 10'd602, 10'd601};
    M = 2'd1; N = 4'd2; comp_model = 1'b1;
    do_reset();
    Enable = 1'b1;
    tick(3);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (Q_next !== trial[k]) begin
        errors++; $display("FAIL sar_trial_%0d: got %0d want %0d", k, Q_next, trial[k]);
      end
      tick(2);
    end
`ifdef LOCK_CTRL_TRACK_EN
    exp_qn = 10'd601;
`else
    exp_qn = 10'd600;
`endif
    checks += 3;
    if (Q !== 10'd600)     begin errors++; $display("FAIL sar_Q: got %0d want 600", Q); end
    if (Q_next !== exp_qn) begin errors++; $display("FAIL sar_Q_next: got %0d want %0d", Q_next, exp_qn); end
    if (Cal_done !== 1'b1) begin errors++; $display("FAIL sar_cal_done: got %0b want 1", Cal_done); end
`ifdef LOCK_CTRL_TRACK_EN
    for (int j = 1; j <= 5; j++) begin
      tick(2);
      checks += 2;
      if (Q !== ((j % 2 == 1) ? 10'd601 : 10'd600)) begin
        errors++; $display("FAIL trk_Q_%0d: got %0d want %0d", j, Q, (j % 2 == 1) ? 601 : 600);
      end
      if (Locked !== (j == 5)) begin
        errors++; $display("FAIL trk_Locked_%0d: got %0b want %0b", j, Locked, (j == 5));
      end
    end
`endif
    comp_model = 1'b0;
  endtask

  task automatic test_reset_mid_sar();
    M = 2'd1; N = 4'd2; comp_model = 1'b0; comp_fix = 1'b1;
    do_reset();
    Enable = 1'b1;
    tick(3 + 9);
    checks++;
    if (Q !== 10'd960) begin errors++; $display("FAIL mid_Q_bit5: got %0d want 960", Q); end
    Reset_CTRL = 1'b1;
    tick(1);
    Reset_CTRL = 1'b0;
    checks += 7;
    if (Q !== 10'd0)        begin errors++; $display("FAIL mid_rst_Q: got %0d want 0", Q); end
    if (Q_next !== 10'd0)   begin errors++; $display("FAIL mid_rst_Q_next: got %0d want 0", Q_next); end
    if (M_counter !== 2'd1) begin errors++; $display("FAIL mid_rst_M: got %0d want 1", M_counter); end
    if (N_counter !== 4'd1) begin errors++; $display("FAIL mid_rst_N: got %0d want 1", N_counter); end
    if (Reset_PD !== 1'b1)  begin errors++; $display("FAIL mid_rst_pd: got %0b want 1", Reset_PD); end
    if (Locked !== 1'b0)    begin errors++; $display("FAIL mid_rst_lock: got %0b want 0", Locked); end
    if (Cal_done !== 1'b0)  begin errors++; $display("FAIL mid_rst_cal: got %0b want 0", Cal_done); end
    tick(2);
    checks++;
    if (Reset_PD !== 1'b1) begin errors++; $display("FAIL mid_restart_pd2: got %0b want 1", Reset_PD); end
    tick(1);
    checks += 2;
    if (Reset_PD !== 1'b0)  begin errors++; $display("FAIL mid_restart_pd3: got %0b want 0", Reset_PD); end
    if (Q_next !== 10'd512) begin errors++; $display("FAIL mid_restart_trial: got %0d want 512", Q_next); end
  endtask

  task automatic test_short_frame();
    logic [3:0] exp_n [4];
    exp_n = '{4'd1, 4'd2, 4'd1, 4'd2};
    M = 2'd0; N = 4'd1; comp_model = 1'b0; comp_fix = 1'b1;
    do_reset();
    Enable = 1'b1;
    tick(3);
    for (int i = 0; i < 4; i++) begin
      checks += 2;
      if (N_counter !== exp_n[i]) begin errors++; $display("FAIL sf_N_%0d: got %0d want %0d", i, N_counter, exp_n[i]); end
      if (M_counter !== 2'd1)     begin errors++; $display("FAIL sf_M_%0d: got %0d want 1", i, M_counter); end
      tick(1);
    end
    tick(15);
    checks++;
    if (Cal_done !== 1'b0) begin errors++; $display("FAIL sf_cal_early: got %0b want 0", Cal_done); end
    tick(1);
    checks++;
    if (Cal_done !== 1'b1) begin errors++; $display("FAIL sf_cal_done: got %0b want 1", Cal_done); end
    tick(3);
    Enable = 1'b0;
    tick(1);
    checks += 5;
    if (Locked !== 1'b0)    begin errors++; $display("FAIL drop_Locked: got %0b want 0", Locked); end
    if (Cal_done !== 1'b0)  begin errors++; $display("FAIL drop_Cal_done: got %0b want 0", Cal_done); end
    if (Reset_PD !== 1'b1)  begin errors++; $display("FAIL drop_Reset_PD: got %0b want 1", Reset_PD); end
    if (Q !== 10'd1023)     begin errors++; $display("FAIL drop_Q: got %0d want 1023", Q); end
    if (N_counter !== 4'd1) begin errors++; $display("FAIL drop_N: got %0d want 1", N_counter); end
  endtask

  initial begin
    test_reset();
    test_comp_high();
    test_comp_low();
    test_sar_search();
    test_reset_mid_sar();
    test_short_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
